// File: rtl/sbox_encrypt_core_if.sv
// sbox_encrypt_core_if: request, key and result bundle for sbox_encrypt_core
interface sbox_encrypt_core_if;
  logic        GLOBAL_EN;
  logic        START;
  logic [31:0] PlainText;
  logic [7:0]  KEY_SEED;
  logic [31:0] CipherText;
  logic [7:0]  K_1;
  logic [7:0]  K_2;
  logic [7:0]  K_3;
  logic        BUSY;
  logic        DONE;
  modport master (
    output GLOBAL_EN, START, PlainText, KEY_SEED,
    input  CipherText, K_1, K_2, K_3, BUSY, DONE
  );
  modport slave (
    input  GLOBAL_EN, START, PlainText, KEY_SEED,
    output CipherText, K_1, K_2, K_3, BUSY, DONE
  );
endinterface

// File: rtl/sbox_encrypt_core.sv
// sbox_encrypt_core: three-round key-xor / S-box / byte-rotate encryptor with on-the-fly key expansion
module sbox_encrypt_core #(
  parameter logic [7:0] SBOX_C = 8'h63,
  parameter logic [7:0] RC2    = 8'h1B,
  parameter logic [7:0] RC3    = 8'h36
) (
  input logic CLK,
  input logic RST,
  sbox_encrypt_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FIN} state_t;
  state_t      state;
  logic [31:0] st;
  logic [1:0]  r;
  logic [7:0]  key;
  logic [7:0]  k2_nxt;
  logic [7:0]  k3_nxt;
  logic [31:0] mixed;
  logic [31:0] subbed;
  logic [31:0] nxt;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return {x[6:0], x[7]} ^ SBOX_C;
  endfunction
  always_comb begin
    key    = r == 2'd1 ? bus.K_1 : r == 2'd2 ? bus.K_2 : bus.K_3;
    mixed  = st ^ {4{key}};
    subbed = {sb(mixed[31:24]), sb(mixed[23:16]), sb(mixed[15:8]), sb(mixed[7:0])};
    nxt    = {subbed[23:0], subbed[31:24]};
    // K_3 chains off the freshly derived K_2 so both land in the single LOAD cycle
    k2_nxt = {bus.K_1[4:0], bus.K_1[7:5]} ^ RC2;
    k3_nxt = {k2_nxt[4:0], k2_nxt[7:5]} ^ RC3;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      st             <= '0;
      r              <= '0;
      bus.CipherText <= '0;
      bus.K_1        <= '0;
      bus.K_2        <= '0;
      bus.K_3        <= '0;
      bus.BUSY       <= 1'b0;
      bus.DONE       <= 1'b0;
    end else if (bus.GLOBAL_EN) begin
      case (state)
        IDLE: if (bus.START) begin
          st       <= bus.PlainText;
          bus.K_1  <= bus.KEY_SEED;
          bus.BUSY <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          bus.K_2 <= k2_nxt;
          bus.K_3 <= k3_nxt;
          r       <= 2'd1;
          state   <= ROUND;
        end
        ROUND: begin
          st <= nxt;
          r  <= r + 2'd1;
          if (r == 2'd3) begin
            bus.CipherText <= nxt;
            bus.BUSY       <= 1'b0;
            bus.DONE       <= 1'b1;
            state          <= FIN;
          end
        end
        FIN: begin
          bus.DONE <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
